vme_cmd_sched: RTL and testbench
================================

Name: vme_cmd_sched

Overview:
- Synthesizable scheduler that shares the single VME command/data register path between NREQ requesters, for example the JTAG sequencer, the test controller and the slow-control host.
- Arbitrates round-robin between requesters and forms the 32-bit command word with the fixed device mask and the R/W bits.
- Issues a one-cycle start, waits for the completion strobe, then returns read data and a done pulse to the winner.
- Drives the same start / vme_cmd_reg / vme_dat_reg_in interface that the simulation command file handler drives.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CMD_MASK, 32'h00a80000, device/select bits ORed into every command word and driven on vme_cmd_reg when idle.
- TIMEOUT, 255, WAIT-state cycles without vme_dat_wr before the command is aborted (8-bit counter, 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; hold high until done
- req_rnw  in  NREQ  1 = read, 0 = write
- req_cmd  in  NREQ*32  command word, requester i at [32i+31:32i]
- req_dat  in  NREQ*32  write data, requester i at [32i+31:32i]
- grant  out  NREQ  one-hot owner of the current transaction, else 0
- done  out  NREQ  one-cycle completion pulse to the owner
- rdata  out  16  captured vme_dat_reg_out[15:0], valid with done
- timeout_err  out  1  one-cycle pulse coincident with done on an aborted command
- busy  out  1  high in any state other than IDLE
- vme_cmd_rd  in  1  downstream ready to accept a command
- vme_dat_wr  in  1  downstream completion strobe
- vme_dat_reg_out  in  32  downstream read data
- start  out  1  one-cycle command-issue strobe
- vme_cmd_reg  out  32  command word
- vme_dat_reg_in  out  32  write data

Behaviour:
- All outputs are registered. Reset values: grant=0, done=0, rdata=0, timeout_err=0, busy=0, start=0, vme_cmd_reg=CMD_MASK, vme_dat_reg_in=0. Round-robin pointer resets to 0; state resets to IDLE.
- Reset asserted mid-transaction aborts immediately to the reset values. No done pulse is generated.
- State machine has states IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If |req and vme_cmd_rd, select winner w: the first set req at or after the pointer, wrapping from NREQ-1 to 0.
  - Register grant=onehot(w) and start=1.
  - vme_cmd_reg = req_cmd[w] | CMD_MASK, then bit25=1 if req_rnw[w], else bit24=1. The other R/W bit is passed through from req_cmd.
  - vme_dat_reg_in = req_dat[w]. Pointer = (w+1) mod NREQ. Go to ISSUE.
  - If vme_cmd_rd=0, stay in IDLE and issue nothing.
- ISSUE: start is high for exactly this one cycle. At the next edge, start=0, clear the counter, go to WAIT. vme_dat_wr is ignored in ISSUE.
- WAIT:
  - vme_cmd_reg and vme_dat_reg_in hold their values. The counter increments each cycle.
  - If vme_dat_wr: rdata=vme_dat_reg_out[15:0] (captured for writes too), go to DONE.
  - Else if counter==TIMEOUT-1: rdata=16'hFFFF, set the timeout flag, go to DONE.
  - vme_dat_wr and timeout in the same cycle: vme_dat_wr wins and timeout_err is not raised.
- DONE:
  - done=grant and timeout_err=flag, both for one cycle.
  - Next edge: grant=0, vme_cmd_reg=CMD_MASK, vme_dat_reg_in=0, go to IDLE.
- Throughput and latency:
  - Minimum 4 cycles per command.
  - Start asserts 1 cycle after a request is seen in IDLE.
  - done asserts 1 cycle after vme_dat_wr.
- Dropping req while granted does not cancel the transaction; done is still pulsed. A new request is considered only in IDLE.
- vme_dat_wr seen in IDLE or DONE is ignored. vme_dat_reg_out is sampled only on the WAIT completion edge.

Decomposition:
- Shared package vme_sched_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, DONE);
  - CMD_RD_BIT=25 and CMD_WR_BIT=24;
  - default CMD_MASK=32'h00a80000;
  - TIMEOUT_VAL=16'hFFFF.
- One sub-module: rr_arbiter (NREQ-wide). Inputs are req, the pointer and an enable; outputs are a one-hot winner and its index. Purely combinational; the pointer register lives in vme_cmd_sched.

Test Plan:
- Single write: req[0]=1, rnw=0, cmd=32'h00001234, dat=32'h0000BEEF, vme_cmd_rd=1 -> start for 1 cycle, vme_cmd_reg=32'h01A81234, vme_dat_reg_in=32'h0000BEEF. Then vme_dat_wr after 3 cycles -> done[0] 1 cycle later; regs return to 32'h00A80000 and 0.
- Read: req[1]=1, rnw=1, cmd=32'h00004000, then vme_dat_wr with vme_dat_reg_out=32'h0000CAFE -> vme_cmd_reg=32'h02A84000, rdata=16'hCAFE with done[1], timeout_err=0.
- Round-robin: req=2'b11 held continuously -> grants alternate 0,1,0,1; each done precedes the next start; no grant overlap.
- Timeout: no vme_dat_wr, TIMEOUT=8 -> done and timeout_err together 8 cycles after entering WAIT, rdata=16'hFFFF. vme_dat_wr exactly on the 8th cycle -> normal completion, no error.
- Backpressure: vme_cmd_rd=0 with req high for 10 cycles -> start stays 0 and vme_cmd_reg=CMD_MASK. Raise vme_cmd_rd -> start appears the next cycle.
- Async reset in WAIT: assert rst between clock edges -> start=0, grant=0, vme_cmd_reg=32'h00A80000 immediately, no done pulse. After release with req held, the transaction restarts from requester 0.

Source files
------------

// File: rtl/vme_sched_pkg.sv
// Shared definitions for the VME command scheduler: state encoding, R/W bit positions and
// the default device mask.
package vme_sched_pkg;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} sched_state_e;

   localparam int unsigned CMD_RD_BIT   = 25;
   localparam int unsigned CMD_WR_BIT   = 24;
   localparam logic [31:0] CMD_MASK_DEF = 32'h00a80000;
   localparam logic [15:0] TIMEOUT_VAL  = 16'hFFFF;

   // Mask is ORed in first; only the bit for the requested direction is forced, the other passes.
   function automatic logic [31:0] form_cmd(input logic [31:0] cmd, input logic rnw,
                                            input logic [31:0] mask);
      logic [31:0] w;
      w = cmd | mask;
      if (rnw) w[CMD_RD_BIT] = 1'b1;
      else     w[CMD_WR_BIT] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/vme_cmd_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ-1.
// The pointer register is owned by the caller.
module rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            en,
   output logic [NREQ-1:0] win_oh,
   output logic [PW-1:0]   win_idx
);

   logic        found;
   logic [PW:0] idx;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (en && !found && req[idx[PW-1:0]]) begin
            win_oh[idx[PW-1:0]] = 1'b1;
            win_idx             = idx[PW-1:0];
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vme_cmd_sched.sv
// Shares the single VME command/data register path between NREQ requesters: round-robin
// arbitration, one-cycle start, wait for completion or timeout, then done to the winner.
module vme_cmd_sched
   import vme_sched_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter logic [31:0] CMD_MASK = CMD_MASK_DEF,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_rnw,
   input  logic [NREQ*32-1:0] req_cmd,
   input  logic [NREQ*32-1:0] req_dat,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic [15:0]        rdata,
   output logic               timeout_err,
   output logic               busy,
   input  logic               vme_cmd_rd,
   input  logic               vme_dat_wr,
   input  logic [31:0]        vme_dat_reg_out,
   output logic               start,
   output logic [31:0]        vme_cmd_reg,
   output logic [31:0]        vme_dat_reg_in
);

   localparam int unsigned PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

   sched_state_e    state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] win_oh;
   logic            win_en;
   logic            win_valid;
   logic [7:0]      cnt_q;
   logic [31:0]     sel_cmd;
   logic [31:0]     sel_dat;
   logic            sel_rnw;
   logic            unused_dat_hi;

   assign win_en        = (state_q == StIdle) && vme_cmd_rd;
   assign win_valid     = |win_oh;
   assign sel_cmd       = req_cmd[32*win_idx +: 32];
   assign sel_dat       = req_dat[32*win_idx +: 32];
   assign sel_rnw       = req_rnw[win_idx];
   assign ptr_nxt       = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   assign unused_dat_hi = ^vme_dat_reg_out[31:16];

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .en      (win_en),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         ptr_q          <= '0;
         cnt_q          <= '0;
         grant          <= '0;
         done           <= '0;
         rdata          <= '0;
         timeout_err    <= 1'b0;
         busy           <= 1'b0;
         start          <= 1'b0;
         vme_cmd_reg    <= CMD_MASK;
         vme_dat_reg_in <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_valid) begin
                  grant          <= win_oh;
                  start          <= 1'b1;
                  busy           <= 1'b1;
                  vme_cmd_reg    <= form_cmd(sel_cmd, sel_rnw, CMD_MASK);
                  vme_dat_reg_in <= sel_dat;
                  ptr_q          <= ptr_nxt;
                  state_q        <= StIssue;
               end
            end
            StIssue: begin
               start   <= 1'b0;
               cnt_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               cnt_q <= cnt_q + 8'd1;
               // A completion strobe on the last allowed cycle beats the timeout.
               if (vme_dat_wr) begin
                  rdata   <= vme_dat_reg_out[15:0];
                  done    <= grant;
                  state_q <= StDone;
               end else if (cnt_q == TMO_LAST) begin
                  rdata       <= TIMEOUT_VAL;
                  done        <= grant;
                  timeout_err <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               done           <= '0;
               timeout_err    <= 1'b0;
               grant          <= '0;
               busy           <= 1'b0;
               vme_cmd_reg    <= CMD_MASK;
               vme_dat_reg_in <= '0;
               state_q        <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vme_cmd_sched.sv
// Transaction-level self-checking bench for vme_cmd_sched with random requests, responses,
// timeouts, backpressure and an asynchronous reset in the middle of a command.
module tb_vme_cmd_sched;

   localparam int          NREQ = 3;
   localparam int          TMO  = 8;
   localparam logic [31:0] MASK = 32'h00a80000;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_rnw;
   logic [NREQ*32-1:0] req_cmd;
   logic [NREQ*32-1:0] req_dat;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic [15:0]        rdata;
   logic               timeout_err;
   logic               busy;
   logic               vme_cmd_rd;
   logic               vme_dat_wr;
   logic [31:0]        vme_dat_reg_out;
   logic               start;
   logic [31:0]        vme_cmd_reg;
   logic [31:0]        vme_dat_reg_in;

   int n_vec     = 0;
   int n_err     = 0;
   int model_ptr = 0;

   always #5 clk = ~clk;

   vme_cmd_sched #(
      .NREQ     (NREQ),
      .CMD_MASK (MASK),
      .TIMEOUT  (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .req_rnw         (req_rnw),
      .req_cmd         (req_cmd),
      .req_dat         (req_dat),
      .grant           (grant),
      .done            (done),
      .rdata           (rdata),
      .timeout_err     (timeout_err),
      .busy            (busy),
      .vme_cmd_rd      (vme_cmd_rd),
      .vme_dat_wr      (vme_dat_wr),
      .vme_dat_reg_out (vme_dat_reg_out),
      .start           (start),
      .vme_cmd_reg     (vme_cmd_reg),
      .vme_dat_reg_in  (vme_dat_reg_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Round-robin rule: first set request at or after the pointer, wrapping.
   function automatic int pick(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (model_ptr + k) % NREQ;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_start"}, 32'(start), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_terr"}, 32'(timeout_err), 0);
      chk({tag, "_cmd"}, vme_cmd_reg, MASK);
      chk({tag, "_dat"}, vme_dat_reg_in, 0);
   endtask

   // Called on a falling edge with the DUT idle; returns on a falling edge with it idle again.
   // delay: WAIT cycle index of the completion strobe (>= TMO means never).
   task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] rnw,
                          input logic [NREQ*32-1:0] cmds, input logic [NREQ*32-1:0] dats,
                          input int delay, input int bp, input logic [31:0] rd_out,
                          input bit drop);
      int              w;
      logic [31:0]     ecmd;
      logic [31:0]     edat;
      logic [NREQ-1:0] eg;
      req        = r;
      req_rnw    = rnw;
      req_cmd    = cmds;
      req_dat    = dats;
      vme_dat_wr = 1'b0;
      vme_cmd_rd = (bp == 0);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_start", 32'(start), 0);
         chk("bp_cmd", vme_cmd_reg, MASK);
         if (i == bp - 1) vme_cmd_rd = 1'b1;
      end
      w         = pick(r);
      model_ptr = (w + 1) % NREQ;
      eg        = '0;
      eg[w]     = 1'b1;
      ecmd      = cmds[32*w +: 32] | MASK;
      ecmd      = rnw[w] ? (ecmd | 32'h0200_0000) : (ecmd | 32'h0100_0000);
      edat      = dats[32*w +: 32];
      @(negedge clk);
      chk("iss_start", 32'(start), 1);
      chk("iss_grant", 32'(grant), 32'(eg));
      chk("iss_cmd", vme_cmd_reg, ecmd);
      chk("iss_dat", vme_dat_reg_in, edat);
      chk("iss_busy", 32'(busy), 1);
      vme_dat_wr      = 1'($urandom);
      vme_dat_reg_out = $urandom;
      if (drop) req = '0;
      for (int j = 0; j < TMO; j++) begin
         @(negedge clk);
         chk("wait_start", 32'(start), 0);
         chk("wait_done", 32'(done), 0);
         chk("wait_grant", 32'(grant), 32'(eg));
         chk("wait_cmd", vme_cmd_reg, ecmd);
         chk("wait_dat", vme_dat_reg_in, edat);
         vme_dat_wr      = (j == delay);
         vme_dat_reg_out = (j == delay) ? rd_out : $urandom;
         if (j == delay) break;
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(eg));
      chk("done_terr", 32'(timeout_err), (delay >= TMO) ? 1 : 0);
      chk("done_rdata", 32'(rdata), (delay >= TMO) ? 32'h0000_FFFF : 32'(rd_out[15:0]));
      chk("done_busy", 32'(busy), 1);
      vme_dat_wr      = 1'($urandom);
      vme_dat_reg_out = $urandom;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      vme_cmd_rd = 1'b0;
      req        = '0;
      check_idle("post");
   endtask

   logic [NREQ*32-1:0] rc;
   logic [NREQ*32-1:0] rd;

   initial begin
      rst             = 1'b1;
      req             = '0;
      req_rnw         = '0;
      req_cmd         = '0;
      req_dat         = '0;
      vme_cmd_rd      = 1'b0;
      vme_dat_wr      = 1'b0;
      vme_dat_reg_out = '0;
      @(negedge clk);
      check_idle("rst");
      chk("rst_rdata", 32'(rdata), 0);
      rst = 1'b0;

      // Single write from requester 0, then a read from requester 1.
      rc = '0; rd = '0;
      rc[31:0] = 32'h0000_1234; rd[31:0] = 32'h0000_BEEF;
      run_txn(3'b001, 3'b000, rc, rd, 2, 0, 32'h0000_0055, 1'b0);
      rc[63:32] = 32'h0000_4000;
      run_txn(3'b010, 3'b010, rc, rd, 1, 0, 32'h0000_CAFE, 1'b0);

      // All requesters held: grants rotate.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            rc[32*i +: 32] = $urandom;
            rd[32*i +: 32] = $urandom;
         end
         run_txn(3'b111, 3'($urandom), rc, rd, $urandom_range(0, 3), 0, $urandom, 1'b0);
      end

      // Timeout, and completion strobe on the last allowed cycle.
      run_txn(3'b100, 3'b100, rc, rd, TMO + 5, 0, 32'h1234_5678, 1'b0);
      run_txn(3'b100, 3'b000, rc, rd, TMO - 1, 0, 32'h0000_A5A5, 1'b0);

      // Backpressure for 10 cycles.
      run_txn(3'b010, 3'b000, rc, rd, 0, 10, 32'h0000_0101, 1'b0);

      // Random traffic, including dropped requests and timeouts.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            rc[32*i +: 32] = $urandom;
            rd[32*i +: 32] = $urandom;
         end
         run_txn(3'($urandom_range(1, 7)), 3'($urandom), rc, rd, $urandom_range(0, TMO + 2),
                 $urandom_range(0, 3), $urandom, 1'($urandom));
      end

      // Park the pointer on requester 1, then reset mid-WAIT with requesters 0 and 1 held.
      run_txn(3'b001, 3'b000, rc, rd, 0, 0, 32'h0, 1'b0);
      req        = 3'b011;
      vme_cmd_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_start", 32'(start), 0);
      chk("arst_grant", 32'(grant), 0);
      chk("arst_cmd", vme_cmd_reg, MASK);
      chk("arst_busy", 32'(busy), 0);
      @(negedge clk);
      chk("arst_done", 32'(done), 0);
      rst       = 1'b0;
      model_ptr = 0;
      run_txn(3'b011, 3'b000, rc, rd, 1, 0, 32'h0000_7777, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
